// File: rtl/aes_sub_bytes_seq.sv
// Iterative forward AES SubBytes engine.
// The 128-bit state is substituted NUM_SBOX bytes per cycle through the FIPS-197
// forward S-box. Both sides use valid/ready handshakes. A completed result can
// hand off on the same edge that the next state is captured.

// Forward S-box lookup table: 8-bit input, 8-bit output, no arithmetic.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];
endmodule

module aes_sub_bytes_seq #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NUM_GRP = 16 / NUM_SBOX;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GRP - 1);

    generate
        if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
              NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_param
            $error("aes_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t                   r_fsm;
    state_t                   w_fsm_nxt;
    logic [GRP_W-1:0]         r_grp;
    logic [127:0]             r_state;
    logic [NUM_SBOX-1:0][7:0] w_sb_in;
    logic [NUM_SBOX-1:0][7:0] w_sb_out;
    logic [127:0]             w_state_sub;
    logic                     w_last;
    logic                     w_accept;

    assign w_last    = (r_grp == GRP_LAST);
    assign w_accept  = in_valid && in_ready;
    assign out_state = r_state;

    // Feed each S-box lane with its byte of the current group (byte 0 = MSB).
    always_comb begin
        w_sb_in = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            if (r_grp == GRP_W'(g)) begin
                for (int l = 0; l < NUM_SBOX; l++) begin
                    w_sb_in[l] = r_state[127-8*(g*NUM_SBOX+l) -: 8];
                end
            end
        end
    end

    generate
        for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
            aes_sbox u_sbox (
                .i_byte (w_sb_in[l]),
                .o_byte (w_sb_out[l])
            );
        end
    endgenerate

    // Write the substituted group back into place; all other bytes hold.
    always_comb begin
        w_state_sub = r_state;
        for (int b = 0; b < 16; b++) begin
            if (r_grp == GRP_W'(b / NUM_SBOX)) begin
                w_state_sub[127-8*b -: 8] = w_sb_out[b % NUM_SBOX];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // Next-state and handshake outputs. DONE passes out_ready through to in_ready
    // so a new state can be captured on the same edge the result is taken.
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) w_fsm_nxt = SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (w_last) w_fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = rst_n && out_ready;
                if (out_ready) w_fsm_nxt = in_valid ? SUB : IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, substitute one group per SUB cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_grp   <= '0;
        end else if (r_fsm == SUB) begin
            r_state <= w_state_sub;
            r_grp   <= w_last ? '0 : r_grp + GRP_W'(1);
        end else if (w_accept) begin
            r_state <= in_state;
            r_grp   <= '0;
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: scoreboard on the NUM_SBOX=4 instance plus
// side instances at NUM_SBOX = 1, 2, 8, 16 for latency and exhaustive byte coverage.
module tb_aes_sub_bytes_seq;
    localparam int NS  = 4;
    localparam int LAT = 16 / NS;
    localparam int EX_N [4] = '{1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    logic               x_iv, x_or;
    logic [127:0]       x_st;
    logic [3:0]         x_ir, x_ov, x_busy;
    logic [3:0][127:0]  x_os;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] sbox_ref [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic [7:0] inv_ref [256];

    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic         prev_ov = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    aes_sub_bytes_seq #(.NUM_SBOX(NS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_ex
        aes_sub_bytes_seq #(.NUM_SBOX(EX_N[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (x_iv),
            .in_ready  (x_ir[g]),
            .in_state  (x_st),
            .out_valid (x_ov[g]),
            .out_ready (x_or),
            .out_state (x_os[g]),
            .busy      (x_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] sub_model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_ref[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_ref[s[127-8*i -: 8]];
        return r;
    endfunction

    // Scoreboard: push on accepted input, compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && !prev_ov && acc_q.size() != 0)
                chk("sb_latency", 128'(cyc - acc_q[0]), 128'(LAT + 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", 128'(out_valid), 128'(0));
                end else begin
                    chk("sb_data", out_state, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sub_model(in_state));
                acc_q.push_back(cyc);
            end
        end
        prev_ov = out_valid;
    end

    // All drivers are called and return aligned to 1ns after a rising edge.
    task automatic send(input logic [127:0] s);
        int t = 0;
        in_valid = 1'b1;
        in_state = s;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [127:0] e);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk(tag, out_state, e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [127:0] s;
        logic [3:0]   seen;
        in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        x_iv = 1'b0; x_st = '0; x_or = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) inv_ref[sbox_ref[i]] = 8'(i);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(0));
        chk("rst_out_state", out_state,       128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 128'(in_ready), 128'(1));
        chk("post_rst_x_rdy", 128'(x_ir), 128'(4'hF));
        @(posedge clk); #1;

        // All-zero state and the FIPS-197 round-1 vector
        send('0);
        expect_out("zero_vec", {16{8'h63}});
        drain();
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        expect_out("fips_vec", 128'hd42711aee0bf98f1b8b45de51e415230);
        drain();

        // Backpressure in DONE with a pending new input
        out_ready = 1'b0;
        send(128'h00112233445566778899aabbccddeeff);
        expect_out("bp_first", sub_model(128'h00112233445566778899aabbccddeeff));
        in_valid = 1'b1;
        in_state = 128'hffeeddccbbaa99887766554433221100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_state", out_state, sub_model(128'h00112233445566778899aabbccddeeff));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Back-to-back: second state captured on the edge the first one leaves
        in_valid = 1'b1;
        in_state = 128'h0123456789abcdeffedcba9876543210;
        @(negedge clk);
        @(posedge clk); #1;
        in_state = 128'hdeadbeefcafef00d5555aaaa12345678;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_overlap", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset while in SUB after two groups
        send(128'h13579bdf2468ace0fedcba9876543210);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_busy_clr",  128'(busy),      128'(0));
        chk("abort_in_ready",  128'(in_ready),  128'(1));
        @(posedge clk); #1;
        send(128'h8899aabbccddeeff0011223344556677);
        drain();

        // Random states
        for (int i = 0; i < 6; i++) send({$urandom, $urandom, $urandom, $urandom});
        drain();

        // Exhaustive byte coverage on the main instance
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = 8'(k*16 + i);
            send(s);
        end
        drain();

        // Exhaustive coverage and latency at NUM_SBOX = 1, 2, 8, 16
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = 8'(k*16 + i);
            x_iv = 1'b1;
            x_st = s;
            seen = '0;
            @(negedge clk);
            chk("ex_ready", 128'(x_ir), 128'(4'hF));
            @(posedge clk); #1;
            x_iv = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (x_ov[g] && !seen[g]) begin
                        seen[g] = 1'b1;
                        chk("ex_latency", 128'(c - 1), 128'(16 / EX_N[g]));
                        chk("ex_data", x_os[g], sub_model(s));
                        chk("ex_inverse", inv_model(x_os[g]), s);
                    end
                end
            end
            chk("ex_seen", 128'(seen), 128'(4'hF));
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
